rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port (we/rd/wd) between the in-order pipeline writeback and the multi-cycle units (divider, FPU-to-int, AMO).
- Keeps a pending-write scoreboard for registers owned by multi-cycle units and raises a stall for hazards at issue.
- Sits between the WB stage / unit result buses and RegFile. Decode consumes stall_o.

---
 rtl/rf_wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback (port 0) and the multi-cycle units (ports 1..N_REQ-1: divider,
//   FPU-to-int, AMO). It also keeps a pending-write scoreboard for registers
//   owned by multi-cycle units and flags decode hazards on those registers.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   issue_valid/rd    multi-cycle instruction dispatched; its destination
//   chk_rs1/rs2/rd    decode registers to check against the scoreboard
//   stall_o           hazard on any checked register
//   req_valid/rd/wd   per-port writeback request (port i at [5i+4:5i], [32i+31:32i])
//   req_ready         one-hot grant; a request completes on valid && ready
//   rf_we/rd/wd       RegFile write port
//
// Arbitration
//   Port 0 has priority, except when a unit has waited through STARVE_MAX
//   consecutive port-0 grants; then port 0 yields for one cycle. Units are
//   served round-robin starting after the last granted unit.
module rf_wb_arbiter #(
  parameter int N_REQ      = 4,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  input  logic [4:0]            chk_rs1,
  input  logic [4:0]            chk_rs2,
  input  logic [4:0]            chk_rd,
  output logic                  stall_o,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [5*N_REQ-1:0]    req_rd,
  input  logic [32*N_REQ-1:0]   req_wd,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rf_we,
  output logic [4:0]            rf_rd,
  output logic [31:0]           rf_wd
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // State
  logic [31:0]      pending;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] starve_cnt;

  // Combinational arbitration signals
  logic             unit_any;
  logic             force_yield;
  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] cand;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] gnt_idx;
  logic             granted;
  logic             unit_granted;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_wd;

  // Scoreboard update signals
  logic [31:0]      set_vec;
  logic [31:0]      clr_vec;
  logic [31:0]      pending_nxt;

  assign unit_any    = |req_valid[N_REQ-1:1];
  assign force_yield = (starve_cnt == CNT_W'(STARVE_MAX)) && unit_any;

  // Round-robin search over units 1..N_REQ-1, starting just after rr_ptr
  // and wrapping from N_REQ-1 back to 1 (port 0 is never a candidate).
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned k = 1; k < N_REQ; k++) begin
      cand = IDX_W'(((32'(rr_ptr) + k - 1) % (N_REQ - 1)) + 1);
      if (!rr_found && req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Grant selection. Gated by rst_n so an in-flight grant disappears in the
  // same cycle reset is asserted rather than waiting for the next edge.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    granted = 1'b0;
    if (rst_n) begin
      if (req_valid[0] && !force_yield) begin
        grant[0] = 1'b1;
        granted  = 1'b1;
      end else if (rr_found) begin
        grant[rr_idx] = 1'b1;
        gnt_idx       = rr_idx;
        granted       = 1'b1;
      end
    end
  end

  assign unit_granted = granted && (gnt_idx != '0);

  // Write-port mux from the (one-hot) granted port; all zero when idle.
  always_comb begin
    sel_rd = '0;
    sel_wd = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_rd = req_rd[5*i +: 5];
        sel_wd = req_wd[32*i +: 32];
      end
    end
  end

  assign req_ready = grant;
  assign rf_we     = granted && (sel_rd != 5'd0);
  assign rf_rd     = sel_rd;
  assign rf_wd     = sel_wd;

  // Scoreboard: only unit writebacks clear; set wins over a same-cycle clear.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && (issue_rd != 5'd0)) begin
      set_vec = 32'd1 << issue_rd;
    end
    if (unit_granted && (sel_rd != 5'd0)) begin
      clr_vec = 32'd1 << sel_rd;
    end
    pending_nxt    = (pending & ~clr_vec) | set_vec;
    pending_nxt[0] = 1'b0;
  end

  // A register whose unit writeback completes this cycle is forwarded by the
  // RegFile, so it does not count as a hazard.
  function automatic logic hz(input logic [4:0] r);
    return (r != 5'd0) && pending[r] && !(unit_granted && (sel_rd == r));
  endfunction

  assign stall_o = hz(chk_rs1) | hz(chk_rs2) | hz(chk_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      rr_ptr     <= IDX_W'(N_REQ - 1);
      starve_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      if (unit_granted) begin
        rr_ptr <= gnt_idx;
      end
      if (unit_granted || !unit_any) begin
        starve_cnt <= '0;
      end else if (grant[0] && (starve_cnt != CNT_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           issue_valid;
  logic [4:0]     issue_rd;
  logic [4:0]     chk_rs1;
  logic [4:0]     chk_rs2;
  logic [4:0]     chk_rd;
  logic           stall_o;
  logic [N-1:0]   req_valid;
  logic [5*N-1:0] req_rd;
  logic [32*N-1:0] req_wd;
  logic [N-1:0]   req_ready;
  logic           rf_we;
  logic [4:0]     rf_rd;
  logic [31:0]    rf_wd;

  rf_wb_arbiter #(.N_REQ(N), .STARVE_MAX(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .chk_rd     (chk_rd),
    .stall_o    (stall_o),
    .req_valid  (req_valid),
    .req_rd     (req_rd),
    .req_wd     (req_wd),
    .req_ready  (req_ready),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wd      (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] ready;
    logic         we;
    logic [4:0]   rd;
    logic [31:0]  wd;
    logic         stall;
  } resp_t;

  resp_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Queue one expected response for the inputs just applied, then advance
  // to one time unit past the next rising edge.
  task automatic expect_cycle(input string nm, input logic [N-1:0] rdy,
                              input logic we, input logic [4:0] rd,
                              input logic [31:0] wd, input logic st);
    resp_t e;
    e.ready = rdy; e.we = we; e.rd = rd; e.wd = wd; e.stall = st;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [4:0] rd,
                         input logic [31:0] wd);
    req_valid[p]      = v;
    req_rd[5*p +: 5]  = rd;
    req_wd[32*p +: 32] = wd;
  endtask

  task automatic clr_reqs();
    req_valid = '0;
    req_rd    = '0;
    req_wd    = '0;
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  initial begin
    resp_t e;
    resp_t a;
    string nm;
    forever begin
      @(negedge clk);
      a.ready = req_ready; a.we = rf_we; a.rd = rf_rd; a.wd = rf_wd; a.stall = stall_o;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got ready=%b we=%b rd=%0d wd=%h stall=%b, expected ready=%b we=%b rd=%0d wd=%h stall=%b",
                   nm, a.ready, a.we, a.rd, a.wd, a.stall, e.ready, e.we, e.rd, e.wd, e.stall);
        end
      end else if (req_ready !== '0 || rf_we !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ready=%b we=%b, expected ready=0 we=0",
                 req_ready, rf_we);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    clr_reqs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    expect_cycle("idle", 4'b0000, 0, 0, 32'h0, 0);

    // Ports 1 and 3 continuously valid: 1,3,1,3
    set_req(1, 1, 5'd10, 32'h11);
    set_req(3, 1, 5'd12, 32'h33);
    for (int i = 0; i < 2; i++) begin
      expect_cycle("rr13_p1", 4'b0010, 1, 10, 32'h11, 0);
      expect_cycle("rr13_p3", 4'b1000, 1, 12, 32'h33, 0);
    end

    // Port 2 joins: 1,2,3,1
    set_req(2, 1, 5'd20, 32'h22);
    expect_cycle("rr123_p1", 4'b0010, 1, 10, 32'h11, 0);
    expect_cycle("rr123_p2", 4'b0100, 1, 20, 32'h22, 0);
    expect_cycle("rr123_p3", 4'b1000, 1, 12, 32'h33, 0);
    expect_cycle("rr123_wrap", 4'b0010, 1, 10, 32'h11, 0);
    clr_reqs();

    // Starvation: port 0 four times, then port 2 forced through
    set_req(0, 1, 5'd3, 32'hA0A0A0A0);
    set_req(2, 1, 5'd7, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) expect_cycle("starve_p0", 4'b0001, 1, 3, 32'hA0A0A0A0, 0);
    expect_cycle("starve_force", 4'b0100, 1, 7, 32'hDEADBEEF, 0);
    // Counter back at 0: port 0 again gets four grants before the unit
    set_req(2, 1, 5'd8, 32'h12345678);
    for (int i = 0; i < 4; i++) expect_cycle("cnt_cleared_p0", 4'b0001, 1, 3, 32'hA0A0A0A0, 0);
    expect_cycle("cnt_cleared_force", 4'b0100, 1, 8, 32'h12345678, 0);
    clr_reqs();

    // Scoreboard: issue rd=5, hazard on each checked source, bypass on writeback
    issue_valid = 1; issue_rd = 5'd5; chk_rs1 = 5'd5;
    expect_cycle("iss5_same_cycle", 4'b0000, 0, 0, 32'h0, 0);
    issue_valid = 0;
    expect_cycle("stall_rs1", 4'b0000, 0, 0, 32'h0, 1);
    chk_rs1 = 0; chk_rs2 = 5'd5;
    expect_cycle("stall_rs2", 4'b0000, 0, 0, 32'h0, 1);
    chk_rs2 = 0; chk_rd = 5'd5;
    expect_cycle("stall_waw", 4'b0000, 0, 0, 32'h0, 1);
    chk_rd = 0; chk_rs1 = 5'd5;
    set_req(1, 1, 5'd5, 32'h55);
    expect_cycle("wb5_bypass", 4'b0010, 1, 5, 32'h55, 0);
    clr_reqs();
    expect_cycle("pend5_cleared", 4'b0000, 0, 0, 32'h0, 0);

    // Port-0 writeback does not clear the scoreboard
    chk_rs1 = 0; issue_valid = 1; issue_rd = 5'd6;
    expect_cycle("iss6", 4'b0000, 0, 0, 32'h0, 0);
    issue_valid = 0; chk_rs1 = 5'd6;
    set_req(0, 1, 5'd6, 32'h66);
    expect_cycle("p0_no_clear", 4'b0001, 1, 6, 32'h66, 1);
    clr_reqs();
    expect_cycle("still_pend6", 4'b0000, 0, 0, 32'h0, 1);
    set_req(3, 1, 5'd6, 32'h606);
    expect_cycle("u3_clear6", 4'b1000, 1, 6, 32'h606, 0);
    clr_reqs();
    expect_cycle("pend6_cleared", 4'b0000, 0, 0, 32'h0, 0);

    // Same-cycle set and clear of rd=9: set wins
    chk_rs1 = 0; issue_valid = 1; issue_rd = 5'd9;
    expect_cycle("iss9", 4'b0000, 0, 0, 32'h0, 0);
    issue_valid = 0; chk_rs1 = 5'd9;
    expect_cycle("stall9", 4'b0000, 0, 0, 32'h0, 1);
    issue_valid = 1; issue_rd = 5'd9;
    set_req(2, 1, 5'd9, 32'h99);
    expect_cycle("set_clr9", 4'b0100, 1, 9, 32'h99, 0);
    issue_valid = 0; clr_reqs();
    expect_cycle("set_wins9", 4'b0000, 0, 0, 32'h0, 1);
    set_req(1, 1, 5'd9, 32'h909);
    expect_cycle("u1_clear9", 4'b0010, 1, 9, 32'h909, 0);
    clr_reqs();
    expect_cycle("pend9_cleared", 4'b0000, 0, 0, 32'h0, 0);

    // issue_rd=0 sets nothing; chk of x0 never stalls
    chk_rs1 = 0; issue_valid = 1; issue_rd = 5'd0;
    expect_cycle("iss0", 4'b0000, 0, 0, 32'h0, 0);
    issue_valid = 0;
    expect_cycle("chk0", 4'b0000, 0, 0, 32'h0, 0);

    // Unit writeback to x0: completes, no write, scoreboard unchanged
    issue_valid = 1; issue_rd = 5'd4;
    expect_cycle("iss4", 4'b0000, 0, 0, 32'h0, 0);
    issue_valid = 0; chk_rs1 = 5'd4;
    set_req(1, 1, 5'd0, 32'h0000FFFF);
    expect_cycle("rd0_wb", 4'b0010, 0, 0, 32'h0000FFFF, 1);
    clr_reqs();
    expect_cycle("rd0_keeps4", 4'b0000, 0, 0, 32'h0, 1);

    // Reset mid-grant: outputs drop immediately, state cleared
    set_req(1, 1, 5'd4, 32'h44);
    rst_n = 1'b0;
    expect_cycle("rst_mid_grant", 4'b0000, 0, 0, 32'h0, 0);
    rst_n = 1'b1;
    clr_reqs();
    expect_cycle("rst_pend_cleared", 4'b0000, 0, 0, 32'h0, 0);
    chk_rs1 = 0;
    set_req(1, 1, 5'd1, 32'h1);
    set_req(2, 1, 5'd2, 32'h2);
    set_req(3, 1, 5'd3, 32'h3);
    expect_cycle("rst_rr_ptr", 4'b0010, 1, 1, 32'h1, 0);
    clr_reqs();
    expect_cycle("end_idle", 4'b0000, 0, 0, 32'h0, 0);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d unchecked responses, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
